// File: rtl/single_port_ram_arbiter.sv
// single_port_ram_arbiter: round-robin sharing of one single-port RAM between requesters A and B
// Ports: clk/rst (sync, active-high); per requester x in {a,b}: x_req, x_we, x_addr, x_wdata in,
// x_gnt (1-cycle pulse in the ACCESS cycle), x_rdata (held), x_rvalid (1-cycle pulse) out;
// ram_data/ram_addr/ram_we to the RAM, ram_q from the RAM (one cycle after the address); busy out.
module single_port_ram_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy
);
   localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
   logic [1:0] state_q, state_d;
   // the last-served port is also the owner of the current access
   logic own_b_q, own_b_d;
   logic we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
   logic start, win_b, resp;
   always_comb begin
      // B wins when alone, or on a tie when A was served last
      win_b = b_req & (~a_req | ~own_b_q);
      start = (state_q == IDLE) & (a_req | b_req);
      resp = state_q == RESP;
      state_d = start ? ACCESS : (state_q == ACCESS) ? (we_q ? IDLE : RESP) : IDLE;
      own_b_d = start ? win_b : own_b_q;
      we_d = start ? (win_b ? b_we : a_we) : we_q;
      addr_d = start ? (win_b ? b_addr : a_addr) : addr_q;
      wdata_d = start ? (win_b ? b_wdata : a_wdata) : wdata_q;
      a_rdata_d = (resp & ~own_b_q) ? ram_q : a_rdata_q;
      b_rdata_d = (resp & own_b_q) ? ram_q : b_rdata_q;
      a_rvalid_d = resp & ~own_b_q;
      b_rvalid_d = resp & own_b_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         own_b_q <= 1'b1;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         own_b_q <= own_b_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
      end
   end
   assign a_gnt = (state_q == ACCESS) & ~own_b_q;
   assign b_gnt = (state_q == ACCESS) & own_b_q;
   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;
   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign ram_addr = addr_q;
   assign ram_data = wdata_q;
   // gated by rst directly so a write caught by reset in its ACCESS cycle is dropped
   assign ram_we = (state_q == ACCESS) & we_q & ~rst;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// tb_single_port_ram_arbiter: random and directed requests checked against a transaction-level model
module tb_single_port_ram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_req = 1'b1, a_we = 1'b0, b_req = 1'b1, b_we = 1'b0;
   logic [5:0] a_addr = '0, b_addr = '0;
   logic [7:0] a_wdata = '0, b_wdata = '0;
   logic a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, busy;
   logic [7:0] a_rdata, b_rdata, ram_data, ram_q;
   logic [5:0] ram_addr;
   int cmp_n = 0, err_n = 0;
   single_port_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
      .busy(busy)
   );
   always #5 clk = ~clk;
   // RAM: initial contents i + 8'h40, registered read
   logic [7:0] ram_m [64];
   initial begin
      for (int i = 0; i < 64; i++) ram_m[i] = 8'(i + 64);
      forever begin
         @(posedge clk);
         ram_q <= ram_m[ram_addr];
         if (ram_we) ram_m[ram_addr] = ram_data;
      end
   end
   // Transaction-level model: a grant blocks new arbitration for 1 edge (write) or 2 edges (read);
   // a write lands one edge after its grant unless reset; read data arrives two edges after grant.
   logic [7:0] mmem [64];
   logic ea_g, eb_g, e_we, ea_rv, eb_rv, e_busy, last_b, wr_pend, rd_b, win, mdl_on;
   logic [5:0] e_addr;
   logic [7:0] e_data, ea_rd, eb_rd;
   int cnt, rd_left;
   initial begin
      for (int i = 0; i < 64; i++) mmem[i] = 8'(i + 64);
      mdl_on = 1'b0;
      forever begin
         @(posedge clk);
         ea_g = 0; eb_g = 0; e_we = 0; ea_rv = 0; eb_rv = 0;
         if (rst) begin
            cnt = 0; rd_left = 0; last_b = 1; wr_pend = 0; rd_b = 0;
            e_addr = 0; e_data = 0; ea_rd = 0; eb_rd = 0; e_busy = 0; mdl_on = 1;
         end else begin
            if (wr_pend) begin mmem[e_addr] = e_data; wr_pend = 0; end
            if (rd_left > 0) begin
               rd_left--;
               if (rd_left == 0) begin
                  if (rd_b) begin eb_rv = 1; eb_rd = mmem[e_addr]; end
                  else begin ea_rv = 1; ea_rd = mmem[e_addr]; end
               end
            end
            if (cnt == 0 && (a_req || b_req)) begin
               win = b_req && (!a_req || !last_b);
               last_b = win; rd_b = win; ea_g = !win; eb_g = win;
               e_addr = win ? b_addr : a_addr;
               e_data = win ? b_wdata : a_wdata;
               if (win ? b_we : a_we) begin e_we = 1; wr_pend = 1; cnt = 1; end
               else begin rd_left = 2; cnt = 2; end
            end else if (cnt > 0) cnt--;
            e_busy = cnt > 0;
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Per-cycle comparison against the model, plus grant log and event counters
   int glog[$];
   int we_cycles = 0, rv_a = 0;
   initial forever begin
      @(negedge clk);
      if (mdl_on) begin
         chk("a_gnt", 32'(a_gnt), 32'(ea_g));
         chk("b_gnt", 32'(b_gnt), 32'(eb_g));
         chk("ram_we", 32'(ram_we), 32'(e_we & !rst));
         chk("ram_addr", 32'(ram_addr), 32'(e_addr));
         chk("ram_data", 32'(ram_data), 32'(e_data));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("a_rvalid", 32'(a_rvalid), 32'(ea_rv));
         chk("b_rvalid", 32'(b_rvalid), 32'(eb_rv));
         chk("a_rdata", 32'(a_rdata), 32'(ea_rd));
         chk("b_rdata", 32'(b_rdata), 32'(eb_rd));
         if (a_gnt) glog.push_back(0);
         if (b_gnt) glog.push_back(1);
         if (ram_we) we_cycles++;
         if (a_rvalid) rv_a++;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic op(input bit p, input bit w, input logic [5:0] ad, input logic [7:0] d,
                     output logic [7:0] q);
      int n;
      q = 8'h00;
      tick();
      if (p) begin b_req = 1; b_we = w; b_addr = ad; b_wdata = d; end
      else begin a_req = 1; a_we = w; a_addr = ad; a_wdata = d; end
      n = 0;
      do begin @(negedge clk); n++; end while (!(p ? b_gnt : a_gnt) && n < 100);
      if (!(p ? b_gnt : a_gnt)) begin
         cmp_n++; err_n++;
         $display("FAIL gnt_timeout port %0d: got no grant expected one within 100 cycles", p);
      end
      tick();
      if (p) begin b_req = 0; b_addr = 6'($urandom); b_wdata = 8'($urandom); end
      else begin a_req = 0; a_addr = 6'($urandom); a_wdata = 8'($urandom); end
      if (!w) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!(p ? b_rvalid : a_rvalid) && n < 10);
         if (p ? b_rvalid : a_rvalid) q = p ? b_rdata : a_rdata;
         else begin
            cmp_n++; err_n++;
            $display("FAIL rvalid_timeout port %0d: got no rvalid expected one within 10 cycles", p);
         end
      end
   endtask
   logic [7:0] q, qa1, qa2, qb1, qb2, qa_r, qb_r;
   int ord, w0, r0;
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, busy}), 32'd0);
      chk("reset_rdata", 32'({a_rdata, b_rdata}), 32'd0);
      tick();
      rst = 0; a_req = 0; b_req = 0;
      op(0, 1, 6'd0, 8'h01, q);
      op(0, 1, 6'd1, 8'h02, q);
      op(0, 1, 6'd2, 8'h03, q);
      op(0, 0, 6'd0, 8'h00, q);
      chk("t2_read0", 32'(q), 32'h01);
      op(0, 0, 6'd1, 8'h00, q);
      chk("t2_read1", 32'(q), 32'h02);
      tick(); rst = 1;
      tick(); rst = 0;
      glog.delete();
      fork
         begin op(0, 0, 6'd2, 8'h00, qa1); op(0, 0, 6'd2, 8'h00, qa2); end
         begin op(1, 0, 6'd2, 8'h00, qb1); op(1, 0, 6'd2, 8'h00, qb2); end
      join
      ord = 0;
      foreach (glog[i]) ord = ord * 10 + glog[i] + 1;
      chk("t3_order", 32'(ord), 32'd1212);
      chk("t3_rdata", 32'({qa1, qa2, qb1, qb2}), 32'h03030303);
      fork
         op(0, 1, 6'd5, 8'hAA, qa1);
         op(1, 0, 6'd5, 8'h00, qb1);
      join
      chk("t4_b_sees_write", 32'(qb1), 32'hAA);
      tick(); a_req = 1; a_we = 1; a_addr = 6'd7; a_wdata = 8'h55;
      tick(); rst = 1; a_req = 0;
      tick(); rst = 0;
      op(0, 0, 6'd7, 8'h00, q);
      chk("t5_write_dropped", 32'(q), 32'h47);
      r0 = rv_a;
      tick(); a_req = 1; a_we = 0; a_addr = 6'd7;
      tick(); rst = 1; a_req = 0;
      tick(); rst = 0;
      repeat (4) tick();
      chk("t5_no_rvalid", 32'(rv_a), 32'(r0));
      w0 = we_cycles;
      op(1, 1, 6'd63, 8'h77, q);
      op(1, 0, 6'd63, 8'h00, q);
      chk("t6_read63", 32'(q), 32'h77);
      chk("t6_we_cycles", 32'(we_cycles - w0), 32'd1);
      fork
         for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            op(0, 1'($urandom), 6'($urandom), 8'($urandom), qa_r);
         end
         for (int j = 0; j < 60; j++) begin
            repeat ($urandom_range(0, 3)) tick();
            op(1, 1'($urandom), 6'($urandom), 8'($urandom), qb_r);
         end
      join
      repeat (4) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end
endmodule
